// File: rtl/dro_pkg.sv
// Shared constants, state encoding and width helper for the DRO storage bank.
package dro_pkg;

    localparam int MODE_DRO  = 0;
    localparam int MODE_NDRO = 1;

    localparam int VIOL_HOLD = 0;
    localparam int VIOL_OVF  = 1;
    localparam int VIOL_W    = 2;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } bank_state_e;

    // Bits needed to hold 0..depth; never narrower than one bit.
    function automatic int cw_f(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dro_cell.sv
// One storage channel: toggle-pulse detection, quantum count, toggle readout,
// hold-window tracking and sticky violation flags.
module dro_cell
    import dro_pkg::*;
#(
    parameter int DEPTH       = 1,
    parameter int MODE        = MODE_DRO,
    parameter int HOLD_CYCLES = 2,
    parameter int CW          = cw_f(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ready,
    input  logic              set,
    input  logic              rd,
    input  logic              viol_clr,
    output logic              out,
    output logic [CW-1:0]     count,
    output logic [VIOL_W-1:0] viol
);

    localparam int              HCW     = cw_f(HOLD_CYCLES);
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
    localparam logic [HCW-1:0]  HOLD_C  = HCW'(HOLD_CYCLES);

    logic              set_q;
    logic              rd_q;
    logic              sp;
    logic              rp;
    logic [HCW-1:0]    last_s;
    logic [HCW-1:0]    last_r;
    logic [HCW-1:0]    last_s_next;
    logic [HCW-1:0]    last_r_next;
    logic [CW-1:0]     count_rd;
    logic [CW-1:0]     count_next;
    logic              out_next;
    logic [VIOL_W-1:0] viol_next;
    logic              hold_hit;
    logic              ovf_hit;

    assign sp = set ^ set_q;
    assign rp = rd ^ rd_q;

    // Read is resolved first on the pre-set count, then the set uses what the read left.
    always_comb begin
        count_rd    = count;
        count_next  = count;
        out_next    = out;
        last_s_next = last_s;
        last_r_next = last_r;
        hold_hit    = 1'b0;
        ovf_hit     = 1'b0;
        viol_next   = viol;

        if (ready) begin
            if (rp && (count != '0)) begin
                out_next = ~out;
                if (MODE == MODE_DRO) begin
                    count_rd = count - CW'(1);
                end
            end
            count_next = count_rd;
            if (sp) begin
                if (count_rd < DEPTH_C) begin
                    count_next = count_rd + CW'(1);
                end else begin
                    ovf_hit = 1'b1;
                end
            end

            hold_hit = (sp && rp) || (rp && (last_s < HOLD_C)) || (sp && (last_r < HOLD_C));

            if (sp) begin
                last_s_next = '0;
            end else if (last_s < HOLD_C) begin
                last_s_next = last_s + HCW'(1);
            end
            if (rp) begin
                last_r_next = '0;
            end else if (last_r < HOLD_C) begin
                last_r_next = last_r + HCW'(1);
            end
        end

        // A violation raised in the clearing cycle must survive the clear.
        if (viol_clr) begin
            viol_next = '0;
        end
        viol_next[VIOL_HOLD] = viol_next[VIOL_HOLD] | hold_hit;
        viol_next[VIOL_OVF]  = viol_next[VIOL_OVF]  | ovf_hit;
    end

    always_ff @(posedge clk) begin
        set_q <= set;
        rd_q  <= rd;
        if (reset) begin
            out    <= 1'b0;
            count  <= '0;
            last_s <= HOLD_C;
            last_r <= HOLD_C;
            viol   <= '0;
        end else begin
            out    <= out_next;
            count  <= count_next;
            last_s <= last_s_next;
            last_r <= last_r_next;
            viol   <= viol_next;
        end
    end

endmodule

// File: rtl/dro_bank.sv
// Bank of independent DRO/NDRO storage channels behind a post-reset
// initialisation delay; pulses arriving before ready are dropped.
module dro_bank
    import dro_pkg::*;
#(
    parameter int CHANNELS     = 4,
    parameter int DEPTH        = 1,
    parameter int MODE         = MODE_DRO,
    parameter int HOLD_CYCLES  = 2,
    parameter int BEGIN_CYCLES = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [CHANNELS-1:0]             set,
    input  logic [CHANNELS-1:0]             rd,
    input  logic                            viol_clr,
    output logic [CHANNELS-1:0]             out,
    output logic [CHANNELS*cw_f(DEPTH)-1:0] count,
    output logic                            ready,
    output logic [CHANNELS-1:0]             viol_hold,
    output logic [CHANNELS-1:0]             viol_ovf
);

    localparam int CW  = cw_f(DEPTH);
    localparam int ICW = cw_f(BEGIN_CYCLES);

    bank_state_e    state;
    bank_state_e    state_next;
    logic [ICW-1:0] init_cnt;
    logic [ICW-1:0] init_cnt_next;
    logic [VIOL_W-1:0] viol_ch [CHANNELS];

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_next;
            init_cnt <= init_cnt_next;
        end
    end

    // Ready is reached on the BEGIN_CYCLES-th edge after reset is released.
    always_comb begin
        state_next    = state;
        init_cnt_next = init_cnt;
        case (state)
            ST_INIT: begin
                if (int'(init_cnt) + 1 >= BEGIN_CYCLES) begin
                    state_next = ST_READY;
                end else begin
                    init_cnt_next = init_cnt + ICW'(1);
                end
            end
            ST_READY: begin
                state_next = ST_READY;
            end
        endcase
    end

    assign ready = (state == ST_READY);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        dro_cell #(
            .DEPTH       (DEPTH),
            .MODE        (MODE),
            .HOLD_CYCLES (HOLD_CYCLES),
            .CW          (CW)
        ) u_cell (
            .clk      (clk),
            .reset    (reset),
            .ready    (ready),
            .set      (set[i]),
            .rd       (rd[i]),
            .viol_clr (viol_clr),
            .out      (out[i]),
            .count    (count[i*CW +: CW]),
            .viol     (viol_ch[i])
        );

        assign viol_hold[i] = viol_ch[i][VIOL_HOLD];
        assign viol_ovf[i]  = viol_ch[i][VIOL_OVF];
    end

endmodule

// File: tb/tb_dro_bank.sv
// Three banks (DEPTH=3 DRO, DEPTH=1 DRO, DEPTH=1 NDRO) share one stimulus table;
// each row's expected outputs are queued on drive and checked after the next edge.
module tb_dro_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [3:0] set;
    logic [3:0] rd;
    logic       viol_clr;

    logic [3:0] out_a, hold_a, ovf_a;
    logic [7:0] cnt_a;
    logic       rdy_a;
    logic [3:0] out_b, cnt_b, hold_b, ovf_b;
    logic       rdy_b;
    logic [3:0] out_c, cnt_c, hold_c, ovf_c;
    logic       rdy_c;

    dro_bank #(.CHANNELS(4), .DEPTH(3), .MODE(0), .HOLD_CYCLES(2), .BEGIN_CYCLES(8)) u_a (
        .clk(clk), .reset(reset), .set(set), .rd(rd), .viol_clr(viol_clr),
        .out(out_a), .count(cnt_a), .ready(rdy_a), .viol_hold(hold_a), .viol_ovf(ovf_a)
    );

    dro_bank #(.CHANNELS(4), .DEPTH(1), .MODE(0), .HOLD_CYCLES(2), .BEGIN_CYCLES(8)) u_b (
        .clk(clk), .reset(reset), .set(set), .rd(rd), .viol_clr(viol_clr),
        .out(out_b), .count(cnt_b), .ready(rdy_b), .viol_hold(hold_b), .viol_ovf(ovf_b)
    );

    dro_bank #(.CHANNELS(4), .DEPTH(1), .MODE(1), .HOLD_CYCLES(2), .BEGIN_CYCLES(8)) u_c (
        .clk(clk), .reset(reset), .set(set), .rd(rd), .viol_clr(viol_clr),
        .out(out_c), .count(cnt_c), .ready(rdy_c), .viol_hold(hold_c), .viol_ovf(ovf_c)
    );

    typedef struct {
        int         idx;
        logic       rst;
        logic [3:0] s;
        logic [3:0] r;
        logic       clr;
        logic       rdy;
        logic [3:0] oa;
        logic [7:0] ca;
        logic [3:0] ha;
        logic [3:0] fa;
        logic [3:0] ob;
        logic [3:0] cb;
        logic [3:0] oc;
        logic [3:0] cc;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic add(input logic rst, input logic [3:0] s, input logic [3:0] r,
                       input logic clr, input logic rdy,
                       input logic [3:0] oa, input logic [7:0] ca,
                       input logic [3:0] ha, input logic [3:0] fa,
                       input logic [3:0] ob, input logic [3:0] cb,
                       input logic [3:0] oc, input logic [3:0] cc);
        vec_t v;
        v.idx = tbl.size();
        v.rst = rst; v.s = s; v.r = r; v.clr = clr; v.rdy = rdy;
        v.oa = oa; v.ca = ca; v.ha = ha; v.fa = fa;
        v.ob = ob; v.cb = cb; v.oc = oc; v.cc = cc;
        tbl.push_back(v);
    endtask

    // Repeat the previous row: inputs unchanged, so no pulses and no state change.
    task automatic rep(input int n);
        vec_t v;
        for (int k = 0; k < n; k++) begin
            v = tbl[tbl.size() - 1];
            v.idx = tbl.size();
            tbl.push_back(v);
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        reset    = v.rst;
        set      = v.s;
        rd       = v.r;
        viol_clr = v.clr;
        exp_q.push_back(v);
    endtask

    always @(posedge clk) begin : scoreboard
        vec_t e;
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput($sformatf("v%0d ready", e.idx),  32'(rdy_a),  32'(e.rdy));
            checkOutput($sformatf("v%0d out_a", e.idx),  32'(out_a),  32'(e.oa));
            checkOutput($sformatf("v%0d cnt_a", e.idx),  32'(cnt_a),  32'(e.ca));
            checkOutput($sformatf("v%0d hold_a", e.idx), 32'(hold_a), 32'(e.ha));
            checkOutput($sformatf("v%0d ovf_a", e.idx),  32'(ovf_a),  32'(e.fa));
            checkOutput($sformatf("v%0d out_b", e.idx),  32'(out_b),  32'(e.ob));
            checkOutput($sformatf("v%0d cnt_b", e.idx),  32'(cnt_b),  32'(e.cb));
            checkOutput($sformatf("v%0d out_c", e.idx),  32'(out_c),  32'(e.oc));
            checkOutput($sformatf("v%0d cnt_c", e.idx),  32'(cnt_c),  32'(e.cc));
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        set      = 4'b0000;
        rd       = 4'b0000;
        viol_clr = 1'b0;

        // rst set   rd    clr rdy | out_a  cnt_a  hold_a ovf_a  | out_b  cnt_b  | out_c  cnt_c
        // Reset, then init gate: set[0] toggled on the 3rd edge must be ignored.
        add(1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 8'h00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000); rep(1);
        add(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 8'h00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000); rep(1);
        add(0, 4'b0001, 4'b0000, 0, 0, 4'b0000, 8'h00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000); rep(4);
        add(0, 4'b0001, 4'b0000, 0, 1, 4'b0000, 8'h00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        // Channel 1: store, read 4 cycles later, read again on empty.
        add(0, 4'b0011, 4'b0000, 0, 1, 4'b0000, 8'h04, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0010); rep(3);
        add(0, 4'b0011, 4'b0010, 0, 1, 4'b0010, 8'h00, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0010); rep(1);
        add(0, 4'b0011, 4'b0000, 0, 1, 4'b0010, 8'h00, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0010); rep(1);
        // Channel 2: four stores 3 cycles apart (overflow), then three reads.
        add(0, 4'b0111, 4'b0000, 0, 1, 4'b0010, 8'h10, 4'b0000, 4'b0000, 4'b0010, 4'b0100, 4'b0000, 4'b0110); rep(2);
        add(0, 4'b0011, 4'b0000, 0, 1, 4'b0010, 8'h20, 4'b0000, 4'b0000, 4'b0010, 4'b0100, 4'b0000, 4'b0110); rep(2);
        add(0, 4'b0111, 4'b0000, 0, 1, 4'b0010, 8'h30, 4'b0000, 4'b0000, 4'b0010, 4'b0100, 4'b0000, 4'b0110); rep(2);
        add(0, 4'b0011, 4'b0000, 0, 1, 4'b0010, 8'h30, 4'b0000, 4'b0100, 4'b0010, 4'b0100, 4'b0000, 4'b0110); rep(2);
        add(0, 4'b0011, 4'b0100, 0, 1, 4'b0110, 8'h20, 4'b0000, 4'b0100, 4'b0110, 4'b0000, 4'b0100, 4'b0110); rep(2);
        add(0, 4'b0011, 4'b0000, 0, 1, 4'b0010, 8'h10, 4'b0000, 4'b0100, 4'b0110, 4'b0000, 4'b0000, 4'b0110); rep(2);
        add(0, 4'b0011, 4'b0100, 0, 1, 4'b0110, 8'h00, 4'b0000, 4'b0100, 4'b0110, 4'b0000, 4'b0100, 4'b0110); rep(1);
        // Channel 3: read one cycle after store; channel 0: same-cycle store and read on empty.
        add(0, 4'b1011, 4'b0100, 0, 1, 4'b0110, 8'h40, 4'b0000, 4'b0100, 4'b0110, 4'b1000, 4'b0100, 4'b1110);
        add(0, 4'b1011, 4'b1100, 0, 1, 4'b1110, 8'h00, 4'b1000, 4'b0100, 4'b1110, 4'b0000, 4'b1100, 4'b1110); rep(1);
        add(0, 4'b1010, 4'b1101, 0, 1, 4'b1110, 8'h01, 4'b1001, 4'b0100, 4'b1110, 4'b0001, 4'b1100, 4'b1111); rep(1);

        // Hand-written corner sequences: viol_clr alone, viol_clr racing a fresh violation,
        // then reset with channel 2 at count 2 and set[2] held high across the reset.
        add(0, 4'b1010, 4'b1101, 1, 1, 4'b1110, 8'h01, 4'b0000, 4'b0000, 4'b1110, 4'b0001, 4'b1100, 4'b1111);
        add(0, 4'b1010, 4'b1101, 0, 1, 4'b1110, 8'h01, 4'b0000, 4'b0000, 4'b1110, 4'b0001, 4'b1100, 4'b1111);
        add(0, 4'b1000, 4'b1111, 1, 1, 4'b1110, 8'h05, 4'b0010, 4'b0000, 4'b1110, 4'b0011, 4'b1110, 4'b1111);
        add(0, 4'b1000, 4'b1111, 0, 1, 4'b1110, 8'h05, 4'b0010, 4'b0000, 4'b1110, 4'b0011, 4'b1110, 4'b1111);
        add(0, 4'b1100, 4'b1111, 0, 1, 4'b1110, 8'h15, 4'b0010, 4'b0000, 4'b1110, 4'b0111, 4'b1110, 4'b1111); rep(2);
        add(0, 4'b1000, 4'b1111, 0, 1, 4'b1110, 8'h25, 4'b0010, 4'b0000, 4'b1110, 4'b0111, 4'b1110, 4'b1111);
        add(1, 4'b1100, 4'b1111, 0, 0, 4'b0000, 8'h00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000); rep(1);
        add(0, 4'b1100, 4'b1111, 0, 0, 4'b0000, 8'h00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000); rep(6);
        add(0, 4'b1100, 4'b1111, 0, 1, 4'b0000, 8'h00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000); rep(3);
        add(0, 4'b1000, 4'b1111, 0, 1, 4'b0000, 8'h10, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0100);

        $display("[TB] applying %0d vectors", tbl.size());
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i]);
        end

        repeat (2) @(posedge clk);
        #2;
        checkOutput("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
